// File: rtl/echo_pkg.sv
// Shared types, widths and address helper for the echo tap scheduler.
package echo_pkg;

   localparam int unsigned DELAY_UNIT_W = 5;
   localparam int unsigned SAMPLE_W     = 12;
   localparam int unsigned ACC_W        = 14;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain,
      StOut
   } echo_state_e;

   // Address of a tap: ptr - samples*d, wrapped to the BRAM depth.
   function automatic int unsigned tap_addr(input int unsigned            ptr,
                                            input int unsigned            samples,
                                            input logic [DELAY_UNIT_W-1:0] d,
                                            input int unsigned            addr_w);
      int unsigned mask;
      mask = (32'd1 << addr_w) - 32'd1;
      return (ptr - samples * 32'(d)) & mask;
   endfunction

endpackage

// File: rtl/echo_tap_scheduler_if.sv
// Single-port delay BRAM port bundle; master side is the scheduler.
interface echo_tap_scheduler_if #(
   parameter int unsigned ADDR_W = 13
);
   import echo_pkg::*;

   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_we;
   logic [SAMPLE_W-1:0] mem_din;
   logic [SAMPLE_W-1:0] mem_dout;

   modport master (output mem_addr, output mem_we, output mem_din, input mem_dout);
   modport slave  (input mem_addr, input mem_we, input mem_din, output mem_dout);

endinterface

// File: rtl/echo_mix_accum.sv
// 14-bit echo mix accumulator with per-tap shift and gating.
// ECHO_SATURATE_EN selects clamping instead of wrapping when narrowing to 12 bits.
module echo_mix_accum
   import echo_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_i,
   input  logic [SAMPLE_W-1:0] sample_i,
   input  logic                rd_i,
   input  logic                rd_on_i,
   input  logic [2:0]          rd_shift_i,
   input  logic [SAMPLE_W-1:0] dout_i,
   output logic [SAMPLE_W-1:0] mix_o
);

   logic signed [ACC_W-1:0] acc_q, acc_d, contrib, sum;
   logic                    pend_q, pend_on_q;
   logic [2:0]              pend_sh_q;

   // Read data arrives one cycle after the read slot, so its gating travels with it.
   always_comb begin
      contrib = '0;
      if (pend_q && pend_on_q) begin
         contrib = {{(ACC_W - SAMPLE_W){dout_i[SAMPLE_W-1]}}, dout_i};
         contrib = contrib >>> pend_sh_q;
      end
      sum   = acc_q + contrib;
      acc_d = load_i ? {{(ACC_W - SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i} : sum;
   end

`ifdef ECHO_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SatMax = 14'sd2047;
   localparam logic signed [ACC_W-1:0] SatMin = -14'sd2048;

   always_comb begin
      mix_o = sum[SAMPLE_W-1:0];
      if (sum > SatMax) begin
         mix_o = 12'h7ff;
      end else if (sum < SatMin) begin
         mix_o = 12'h800;
      end
   end
`else
   logic unused_sum;
   assign unused_sum = ^sum[ACC_W-1:SAMPLE_W];
   assign mix_o      = sum[SAMPLE_W-1:0];
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q     <= '0;
         pend_q    <= 1'b0;
         pend_on_q <= 1'b0;
         pend_sh_q <= '0;
      end else begin
         acc_q     <= acc_d;
         pend_q    <= rd_i;
         pend_on_q <= rd_on_i;
         pend_sh_q <= rd_shift_i;
      end
   end

endmodule

// File: rtl/echo_tap_scheduler.sv
// Per-sample sequencer sharing one delay BRAM between a write and NUM_TAPS tap reads.
// Build with ECHO_SATURATE_EN to clamp the mix instead of wrapping it.
module echo_tap_scheduler
   import echo_pkg::*;
#(
   parameter int unsigned SAMPLES  = 240,
   parameter int unsigned NUM_TAPS = 3,
   parameter int unsigned ADDR_W   = 13
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             ready,
   input  logic [SAMPLE_W-1:0]              incoming_sample,
   input  logic [DELAY_UNIT_W*NUM_TAPS-1:0] tap_delays,
   output logic [SAMPLE_W-1:0]              modified_sample,
   output logic                             done,
   output logic                             busy,
   echo_tap_scheduler_if.master             mem
);

   echo_state_e                      state_q, state_d;
   logic [1:0]                       k_q, k_d;
   logic [ADDR_W-1:0]                wr_ptr_q, wr_ptr_d, fill_q, fill_d;
   logic [SAMPLE_W-1:0]              sample_q, out_q, out_d, mix;
   logic [DELAY_UNIT_W*NUM_TAPS-1:0] delays_q;
   logic [DELAY_UNIT_W-1:0]          delay_k;
   logic                             tap_on, load, rd;
   logic [2:0]                       rd_shift;
   logic [ADDR_W-1:0]                addr;
   logic                             we;
   logic [SAMPLE_W-1:0]              din;

   assign delay_k = delays_q[DELAY_UNIT_W*int'(k_q) +: DELAY_UNIT_W];
   // Taps reaching back past the samples written since reset would read stale BRAM.
   assign tap_on  = (delay_k != '0) && (32'(fill_q) >= SAMPLES * 32'(delay_k));

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      out_d    = out_q;
      addr     = '0;
      we       = 1'b0;
      din      = '0;
      load     = 1'b0;
      rd       = 1'b0;
      rd_shift = 3'(k_q) + 3'd1;
      done     = 1'b0;
      busy     = (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            if (ready) state_d = StWrite;
         end
         StWrite: begin
            addr    = wr_ptr_q;
            we      = 1'b1;
            din     = sample_q;
            load    = 1'b1;
            k_d     = '0;
            state_d = StRead;
         end
         StRead: begin
            addr = ADDR_W'(tap_addr(32'(wr_ptr_q), SAMPLES, delay_k, ADDR_W));
            rd   = 1'b1;
            if (32'(k_q) == NUM_TAPS - 1) state_d = StDrain;
            else k_d = k_q + 2'd1;
         end
         StDrain: begin
            out_d   = mix;
            state_d = StOut;
         end
         StOut: begin
            done     = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != {ADDR_W{1'b1}}) fill_d = fill_q + 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         k_q      <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         out_q    <= '0;
         sample_q <= '0;
         delays_q <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         out_q    <= out_d;
         if (state_q == StIdle && ready) begin
            sample_q <= incoming_sample;
            delays_q <= tap_delays;
         end
      end
   end

   echo_mix_accum u_accum (
      .clk_i     (clock),
      .rst_ni    (reset),
      .load_i    (load),
      .sample_i  (sample_q),
      .rd_i      (rd),
      .rd_on_i   (tap_on),
      .rd_shift_i(rd_shift),
      .dout_i    (mem.mem_dout),
      .mix_o     (mix)
   );

   assign modified_sample = out_q;
   assign mem.mem_addr    = addr;
   assign mem.mem_we      = we;
   assign mem.mem_din     = din;

endmodule

// File: tb/tb_echo_tap_scheduler.sv
// Self-checking bench for echo_tap_scheduler with a behavioural 8192x12 BRAM.
module tb_echo_tap_scheduler;
   import echo_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ready = 1'b0;
   logic [11:0] incoming_sample = '0;
   logic [14:0] tap_delays = '0;
   logic [11:0] modified_sample;
   logic        done, busy;

   echo_tap_scheduler_if #(.ADDR_W(13)) mem_if ();

   echo_tap_scheduler #(.SAMPLES(240), .NUM_TAPS(3), .ADDR_W(13)) dut (
      .clock          (clock),
      .reset          (reset),
      .ready          (ready),
      .incoming_sample(incoming_sample),
      .tap_delays     (tap_delays),
      .modified_sample(modified_sample),
      .done           (done),
      .busy           (busy),
      .mem            (mem_if)
   );

   always #5 clock = ~clock;

   logic [11:0] bram [8192];
   always @(posedge clock) begin
      if (mem_if.mem_we) bram[mem_if.mem_addr] <= mem_if.mem_din;
      mem_if.mem_dout <= bram[mem_if.mem_addr];
   end

   int          wr_cnt = 0;
   int          last_waddr = -1;
   int          last_wdata = 0;
   always @(negedge clock) begin
      if (reset && mem_if.mem_we) begin
         wr_cnt     = wr_cnt + 1;
         last_waddr = int'(mem_if.mem_addr);
         last_wdata = int'($signed(mem_if.mem_din));
      end
   end

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // One full transaction; inputs are scrambled right after acceptance.
   task automatic run_sample(input int s, input logic [14:0] d,
                             output int out, output int lat, output int busy_ok);
      @(negedge clock);
      ready = 1'b1; incoming_sample = 12'(s); tap_delays = d;
      @(negedge clock);
      ready = 1'b0; incoming_sample = ~incoming_sample; tap_delays = ~d;
      lat = -1; busy_ok = 1;
      for (int c = 1; c <= 20; c++) begin
         if (!busy) busy_ok = 0;
         if (done) begin
            lat = c;
            break;
         end
         @(negedge clock);
      end
      out = int'($signed(modified_sample));
   endtask

   task automatic pulse_reset();
      @(negedge clock); reset = 1'b0;
      @(negedge clock); reset = 1'b1;
   endtask

   typedef struct {
      int          s;
      logic [14:0] d;
      int          exp;
   } vec_t;

   vec_t vecs[8];
   int   out, lat, bok, bad, bad2, dcnt, wc0, first_done;

   initial begin
      vecs[0] = '{s: -5,    d: 15'd0,                    exp: -5};
      vecs[1] = '{s: 2047,  d: 15'd0,                    exp: 2047};
      vecs[2] = '{s: -2048, d: 15'd0,                    exp: -2048};
      vecs[3] = '{s: 0,     d: {5'd0, 5'd0, 5'd1},       exp: 0};
      vecs[4] = '{s: 1234,  d: {5'd31, 5'd2, 5'd1},      exp: 1234};
      vecs[5] = '{s: -1,    d: 15'd0,                    exp: -1};
      vecs[6] = '{s: 321,   d: 15'h7fff,                 exp: 321};
      vecs[7] = '{s: 1,     d: 15'd0,                    exp: 1};

      repeat (2) @(negedge clock);
      check("reset_out", int'(modified_sample), 0);
      check("reset_done", int'(done), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_we", int'(mem_if.mem_we), 0);
      reset = 1'b1;

      // Bypass and warm-up gating vectors: fill is tiny, so every tap is off.
      for (int i = 0; i < 8; i++) begin
         run_sample(vecs[i].s, vecs[i].d, out, lat, bok);
         check($sformatf("vec%0d_out", i), out, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), lat, 6);
         check($sformatf("vec%0d_busy", i), bok, 1);
         check($sformatf("vec%0d_waddr", i), last_waddr, i);
         check($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].s);
      end

      // Reset during the WRITE cycle.
      @(negedge clock);
      ready = 1'b1; incoming_sample = 12'd55; tap_delays = '0;
      @(negedge clock);
      ready = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("midrst_out", int'(modified_sample), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_we", int'(mem_if.mem_we), 0);
      check("midrst_addr", int'(mem_if.mem_addr), 0);
      check("midrst_din", int'(mem_if.mem_din), 0);
      dcnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (done) dcnt++;
      end
      check("midrst_no_done", dcnt, 0);
      reset = 1'b1;
      run_sample(77, 15'd0, out, lat, bok);
      check("postrst_waddr", last_waddr, 0);
      check("postrst_out", out, 77);

      // Overrun: a second ready two cycles in is dropped.
      wc0 = wr_cnt;
      @(negedge clock);
      ready = 1'b1; incoming_sample = 12'd500; tap_delays = '0;
      @(negedge clock);
      ready = 1'b0; incoming_sample = 12'hfff;
      @(negedge clock);
      ready = 1'b1; incoming_sample = -12'sd700;
      @(negedge clock);
      ready = 1'b0;
      dcnt = 0; first_done = -1;
      for (int c = 3; c < 23; c++) begin
         if (done) begin
            dcnt++;
            if (first_done < 0) first_done = c;
         end
         @(negedge clock);
      end
      check("overrun_done_count", dcnt, 1);
      check("overrun_latency", first_done, 6);
      check("overrun_out", int'($signed(modified_sample)), 500);
      check("overrun_writes", wr_cnt - wc0, 1);
      check("overrun_wdata", last_wdata, 500);
      run_sample(9, 15'd0, out, lat, bok);
      check("overrun_next_waddr", last_waddr, 2);

      // Single tap impulse response.
      pulse_reset();
      bad = 0;
      for (int n = 0; n <= 240; n++) begin
         run_sample((n == 0) ? 800 : 0, 15'd1, out, lat, bok);
         if (n == 0) check("impulse_s0", out, 800);
         else if (n == 240) check("impulse_s240", out, 400);
         else if (out != 0 || lat != 6) bad++;
      end
      check("impulse_others_bad", bad, 0);

      // Warm-up gating on the longest delay.
      pulse_reset();
      bad = 0; bad2 = 0;
      for (int n = 0; n <= 7443; n++) begin
         run_sample(100, 15'd31, out, lat, bok);
         if (n < 7440) begin
            if (out != 100) bad++;
         end else if (n == 7440) check("warm_s7440", out, 150);
         else if (out != 150) bad2++;
      end
      check("warm_pre_bad", bad, 0);
      check("warm_post_bad", bad2, 0);

      // Narrowing with taps {1,2,3}.
      pulse_reset();
      for (int n = 0; n < 740; n++) run_sample(2000, {5'd3, 5'd2, 5'd1}, out, lat, bok);
`ifdef ECHO_SATURATE_EN
      check("narrow_pos", out, 2047);
`else
      check("narrow_pos", out, -346);
`endif
      for (int n = 0; n < 730; n++) run_sample(-2048, {5'd3, 5'd2, 5'd1}, out, lat, bok);
`ifdef ECHO_SATURATE_EN
      check("narrow_neg", out, -2048);
`else
      check("narrow_neg", out, 256);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/echo_tap_scheduler.md
Name: echo_tap_scheduler

Overview:
Per-sample sequencer that owns one single-port 8192x12 delay BRAM and time-shares it between one write and NUM_TAPS tap reads. Each audio sample produces a multi-tap echo mix. It sits between the 24 kHz sample-ready strobe from the audio front end and the effects output path. It drives the mybram instance through explicit memory ports.

Parameters:
SAMPLES, 240, samples per 10 ms delay unit.
NUM_TAPS, 3, number of echo taps; legal range 1..4.
ADDR_W, 13, BRAM address width; depth is 2^ADDR_W.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
ready  in  1  one-cycle strobe: new incoming_sample valid
incoming_sample  in  12  signed dry sample
tap_delays  in  5*NUM_TAPS  tap k delay in 10 ms units at bits [5k+4:5k]; 0 means tap off
modified_sample  out  12  signed mixed sample; held until next done
done  out  1  one-cycle pulse: modified_sample updated
busy  out  1  high from the cycle after an accepted ready until done
mem_addr  out  ADDR_W  BRAM address
mem_we  out  1  BRAM write enable
mem_din  out  12  BRAM write data
mem_dout  in  12  BRAM read data, valid 1 cycle after the address is presented

Behaviour:
- Reset (reset=0, async): state IDLE; wr_ptr=0; fill=0; modified_sample=0; done=0; busy=0; mem_we=0; mem_addr=0; mem_din=0. BRAM contents are not cleared. Reset mid-sequence aborts the sequence with no done pulse.
- Capture: in IDLE with ready=1, latch incoming_sample and tap_delays. Later changes on these inputs do not affect the current sequence. ready in any other state is ignored: no queueing, no pointer change.
- FSM: IDLE -> WRITE -> READ (NUM_TAPS cycles, k=0..NUM_TAPS-1) -> DRAIN -> OUT -> IDLE.
- WRITE: mem_addr=wr_ptr, mem_we=1, mem_din=latched sample; acc = sign-extended sample.
- READ k: mem_addr = wr_ptr - SAMPLES*delay_k (mod 2^ADDR_W), mem_we=0. The data returned in READ k+1 or DRAIN is added to acc as tap_k >>> (k+1), an arithmetic shift with floor rounding.
- Tap gating: tap k contributes 0 if delay_k==0 or fill < SAMPLES*delay_k, which prevents stale BRAM data after reset. The read slot is still consumed, so latency is fixed.
- OUT: modified_sample = acc narrowed to 12 bits; done=1 for this cycle; wr_ptr += 1 with natural wrap at 2^ADDR_W; fill += 1, saturating at 2^ADDR_W-1.
- Latency: done asserts NUM_TAPS+3 cycles after the accepted ready (6 for the default). Throughput is one sample per NUM_TAPS+3 cycles, far above 24 kHz.
- Accumulator is 14-bit signed; the worst-case magnitude is below 2x full scale.
- With all delays 0, modified_sample equals incoming_sample exactly.
- Max delay is 31*240=7440 < 8192, so a tap address never aliases the current write.

Optional Feature:
ECHO_SATURATE_EN
- Defined: narrowing clamps acc to [-2048, 2047].
- Undefined: narrowing keeps acc[11:0], i.e. two's-complement wrap.

Decomposition:
- Shared package (echo_pkg):
  - DELAY_UNIT_W=5
  - SAMPLE_W=12
  - ACC_W=14
  - FSM state encoding (IDLE, WRITE, READ, DRAIN, OUT)
  - a tap address function (ptr - SAMPLES*d, mod depth)
- Sub-module echo_mix_accum: 14-bit accumulator with per-tap shift, gating and the saturate/wrap narrowing.
- mybram is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold reset=0 mid-sequence -> modified_sample=0, done=0, busy=0, mem_we=0 immediately; after release, the next ready writes to address 0.
- Bypass: all delays 0, ready with sample -5 -> done exactly 6 cycles later, modified_sample=-5, one write at wr_ptr.
- Single tap: tap0=1, others 0; impulse 800 at sample 0, then zeros -> sample 0 out=800; sample 240 out=400; all other samples 0.
- Warm-up gating: after reset, tap0=31, constant input 100 -> out=100 for samples 0..7439; out=150 from sample 7440.
- Saturation: taps {1,2,3}, constant 2000 for 720+ samples.
  - With ECHO_SATURATE_EN -> out 2047.
  - Without -> out -346.
  - Constant -2048 with SAT -> -2048.
- Overrun: second ready 2 cycles after an accepted ready -> exactly one done; wr_ptr advanced by 1; the second sample is never written.
